// File: rtl/pattern_capture.sv
// Logic-analyzer capture engine: samples synchronized GPIO on a programmable
// two-stage timebase, packs samples LSB-first into bytes and writes them to BRAM.
module pattern_capture #(
    parameter int ADDR_BITS   = 13,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_cap,
    input  logic [ADDR_BITS-1:0] end_address_cap,
    input  logic [1:0]           num_gpio_sel_cap,
    input  logic [2:0]           timestep_sel_cap,
    input  logic [3:0]           stage1_count_sel_cap,
    input  logic                 circular_enable_cap,
    input  logic                 trigger_enable_cap,
    input  logic [7:0]           gpio_cap_in,
    output logic                 capture_active,
    output logic                 capture_done,
    output logic [ADDR_BITS-1:0] capture_last_addr,
    output logic [ADDR_BITS-1:0] bram_addr,
    output logic [7:0]           bram_write_data,
    output logic                 bram_wen
);

    localparam int SYNC_DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [20:0] STAGE2_ONES = '1;
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

    state_t                      state;
    logic [SYNC_DEPTH-1:0][7:0]  sync_q;
    logic [7:0]                  gpio_s;
    logic                        gpio0_prev;

    logic [ADDR_BITS-1:0]        end_r;
    logic [1:0]                  num_r;
    logic [2:0]                  ts_r;
    logic [3:0]                  s1_r;
    logic                        circ_r;

    logic [3:0]                  stage1;
    logic [20:0]                 stage2;
    logic [20:0]                 stage2_max;
    logic [2:0]                  pack_cnt;
    logic [2:0]                  pack_last;
    logic [7:0]                  pack_reg;
    logic [7:0]                  packed_next;
    logic [ADDR_BITS-1:0]        addr;
    logic [ADDR_BITS-1:0]        addr_next;

    logic                        trigger_edge;
    logic                        sample_strobe;
    logic                        start_capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            gpio0_prev <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_DEPTH-2:0], gpio_cap_in};
            gpio0_prev <= sync_q[SYNC_DEPTH-1][0];
        end
    end

    assign gpio_s        = sync_q[SYNC_DEPTH-1];
    assign trigger_edge  = gpio_s[0] & ~gpio0_prev;
    assign sample_strobe = (stage1 == 4'd0) && (stage2 == 21'd0);
    assign stage2_max    = ~(STAGE2_ONES << (5'd3 * {2'b00, ts_r}));
    assign addr_next     = (addr == end_r) ? '0 : addr + ADDR_ONE;
    assign start_capture = ((state == IDLE) && enable_cap && !trigger_enable_cap) ||
                           ((state == ARM) && enable_cap && trigger_edge);

    // New sample enters at the top so the first sample drifts down to bit 0.
    always_comb begin
        packed_next = gpio_s;
        pack_last   = 3'd0;
        case (num_r)
            2'd0: begin
                packed_next = {gpio_s[0], pack_reg[7:1]};
                pack_last   = 3'd7;
            end
            2'd1: begin
                packed_next = {gpio_s[1:0], pack_reg[7:2]};
                pack_last   = 3'd3;
            end
            2'd2: begin
                packed_next = {gpio_s[3:0], pack_reg[7:4]};
                pack_last   = 3'd1;
            end
            2'd3: begin
                packed_next = gpio_s;
                pack_last   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            capture_active    <= 1'b0;
            capture_done      <= 1'b0;
            capture_last_addr <= '0;
            bram_addr         <= '0;
            bram_write_data   <= '0;
            bram_wen          <= 1'b0;
            end_r             <= '0;
            num_r             <= '0;
            ts_r              <= '0;
            s1_r              <= '0;
            circ_r            <= 1'b0;
            stage1            <= '0;
            stage2            <= '0;
            pack_cnt          <= '0;
            pack_reg          <= '0;
            addr              <= '0;
        end else begin
            bram_wen <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable_cap) begin
                        capture_active <= 1'b1;
                        state          <= trigger_enable_cap ? ARM : CAPTURE;
                    end
                end

                ARM: begin
                    if (!enable_cap) begin
                        capture_active <= 1'b0;
                        state          <= IDLE;
                    end else if (trigger_edge) begin
                        state <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    if (!enable_cap) begin
                        // Circular captures end on enable drop; linear ones abort.
                        capture_active <= 1'b0;
                        capture_done   <= circ_r;
                        state          <= circ_r ? DONE : IDLE;
                    end else begin
                        if (stage1 == s1_r) begin
                            stage1 <= '0;
                            stage2 <= (stage2 == stage2_max) ? 21'd0 : stage2 + 21'd1;
                        end else begin
                            stage1 <= stage1 + 4'd1;
                        end

                        if (sample_strobe) begin
                            if (pack_cnt == pack_last) begin
                                pack_cnt          <= '0;
                                pack_reg          <= '0;
                                bram_wen          <= 1'b1;
                                bram_write_data   <= packed_next;
                                bram_addr         <= addr;
                                capture_last_addr <= addr;
                                addr              <= addr_next;
                                if ((addr == end_r) && !circ_r) begin
                                    capture_active <= 1'b0;
                                    capture_done   <= 1'b1;
                                    state          <= DONE;
                                end
                            end else begin
                                pack_cnt <= pack_cnt + 3'd1;
                                pack_reg <= packed_next;
                            end
                        end
                    end
                end

                DONE: begin
                    if (!enable_cap) begin
                        capture_done <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase

            // Configuration is frozen at the moment the capture begins.
            if (start_capture) begin
                end_r    <= end_address_cap;
                num_r    <= num_gpio_sel_cap;
                ts_r     <= timestep_sel_cap;
                s1_r     <= stage1_count_sel_cap;
                circ_r   <= circular_enable_cap;
                stage1   <= '0;
                stage2   <= '0;
                pack_cnt <= '0;
                pack_reg <= '0;
                addr     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pattern_capture.sv
// Self-checking bench for pattern_capture: a behavioural model predicts every
// output each cycle; literal expectations pin both model and DUT per scenario.
`timescale 1ns/1ps
module tb_pattern_capture;

    localparam int ADDR_BITS   = 13;
    localparam int SYNC_STAGES = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 enable_cap = 1'b0;
    logic [ADDR_BITS-1:0] end_address_cap = '0;
    logic [1:0]           num_gpio_sel_cap = '0;
    logic [2:0]           timestep_sel_cap = '0;
    logic [3:0]           stage1_count_sel_cap = '0;
    logic                 circular_enable_cap = 1'b0;
    logic                 trigger_enable_cap = 1'b0;
    logic [7:0]           gpio_cap_in = '0;
    logic                 capture_active;
    logic                 capture_done;
    logic [ADDR_BITS-1:0] capture_last_addr;
    logic [ADDR_BITS-1:0] bram_addr;
    logic [7:0]           bram_write_data;
    logic                 bram_wen;

    pattern_capture #(
        .ADDR_BITS   (ADDR_BITS),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .enable_cap           (enable_cap),
        .end_address_cap      (end_address_cap),
        .num_gpio_sel_cap     (num_gpio_sel_cap),
        .timestep_sel_cap     (timestep_sel_cap),
        .stage1_count_sel_cap (stage1_count_sel_cap),
        .circular_enable_cap  (circular_enable_cap),
        .trigger_enable_cap   (trigger_enable_cap),
        .gpio_cap_in          (gpio_cap_in),
        .capture_active       (capture_active),
        .capture_done         (capture_done),
        .capture_last_addr    (capture_last_addr),
        .bram_addr            (bram_addr),
        .bram_write_data      (bram_write_data),
        .bram_wen             (bram_wen)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    typedef enum int {M_IDLE, M_ARM, M_CAP, M_DONE} mstate_t;

    mstate_t    m_state = M_IDLE;
    logic [7:0] m_hist [SYNC_STAGES];
    logic       m_prev0 = 1'b0;
    int         m_elapsed = 0;
    int         m_period = 1;
    int         m_width = 8;
    int         m_end = 0;
    bit         m_circ = 1'b0;
    int         m_addr = 0;
    int         m_samples [$];

    bit exp_active = 1'b0;
    bit exp_done   = 1'b0;
    bit exp_wen    = 1'b0;
    int exp_last   = 0;
    int exp_addr   = 0;
    int exp_data   = 0;

    int mlog_addr [$];
    int mlog_data [$];
    int dlog_addr [$];
    int dlog_data [$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelStart();
        m_state   = M_CAP;
        m_period  = (int'(stage1_count_sel_cap) + 1) * (1 << (3 * int'(timestep_sel_cap)));
        m_width   = 1 << int'(num_gpio_sel_cap);
        m_end     = int'(end_address_cap);
        m_circ    = circular_enable_cap;
        m_elapsed = 0;
        m_addr    = 0;
        m_samples.delete();
    endtask

    // One clock of spec-level behaviour: time since capture start decides sampling.
    task automatic modelStep();
        logic [7:0] g;
        int         b;
        g       = m_hist[SYNC_STAGES-1];
        exp_wen = 1'b0;
        case (m_state)
            M_IDLE: if (enable_cap) begin
                exp_active = 1'b1;
                if (trigger_enable_cap) m_state = M_ARM;
                else modelStart();
            end
            M_ARM: if (!enable_cap) begin
                m_state    = M_IDLE;
                exp_active = 1'b0;
            end else if (g[0] && !m_prev0) begin
                modelStart();
            end
            M_CAP: if (!enable_cap) begin
                exp_active = 1'b0;
                if (m_circ) begin
                    m_state  = M_DONE;
                    exp_done = 1'b1;
                end else begin
                    m_state = M_IDLE;
                end
            end else begin
                if (m_elapsed % m_period == 0) begin
                    m_samples.push_back(int'(g) & ((1 << m_width) - 1));
                    if (m_samples.size() == 8 / m_width) begin
                        b = 0;
                        foreach (m_samples[i]) b = b | (m_samples[i] << (i * m_width));
                        exp_wen  = 1'b1;
                        exp_addr = m_addr;
                        exp_data = b;
                        exp_last = m_addr;
                        mlog_addr.push_back(m_addr);
                        mlog_data.push_back(b);
                        m_samples.delete();
                        if (m_addr == m_end) begin
                            if (m_circ) begin
                                m_addr = 0;
                            end else begin
                                m_state    = M_DONE;
                                exp_active = 1'b0;
                                exp_done   = 1'b1;
                            end
                        end else begin
                            m_addr++;
                        end
                    end
                end
                m_elapsed++;
            end
            M_DONE: if (!enable_cap) begin
                m_state  = M_IDLE;
                exp_done = 1'b0;
            end
            default: m_state = M_IDLE;
        endcase
        m_prev0 = g[0];
        for (int i = SYNC_STAGES - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = gpio_cap_in;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state    = M_IDLE;
            m_prev0    = 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = '0;
            m_samples.delete();
            exp_active = 1'b0;
            exp_done   = 1'b0;
            exp_wen    = 1'b0;
            exp_last   = 0;
            exp_addr   = 0;
            exp_data   = 0;
        end else begin
            modelStep();
        end
    end

    always @(negedge clk) begin
        checkOutput("capture_active", int'(capture_active), int'(exp_active));
        checkOutput("capture_done", int'(capture_done), int'(exp_done));
        checkOutput("bram_wen", int'(bram_wen), int'(exp_wen));
        checkOutput("capture_last_addr", int'(capture_last_addr), exp_last);
        if (exp_wen) begin
            checkOutput("bram_addr", int'(bram_addr), exp_addr);
            checkOutput("bram_write_data", int'(bram_write_data), exp_data);
        end
        if (bram_wen) begin
            dlog_addr.push_back(int'(bram_addr));
            dlog_data.push_back(int'(bram_write_data));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit circ, input bit trig, input int num,
                                 input int ts, input int s1, input int end_addr);
        circular_enable_cap  = circ;
        trigger_enable_cap   = trig;
        num_gpio_sel_cap     = 2'(num);
        timestep_sel_cap     = 3'(ts);
        stage1_count_sel_cap = 4'(s1);
        end_address_cap      = ADDR_BITS'(end_addr);
        mlog_addr.delete();
        mlog_data.delete();
        dlog_addr.delete();
        dlog_data.delete();
    endtask

    task automatic checkLog(input string name, input int idx, input int addr, input int data);
        checkOutput({name, " dut addr"}, (idx < dlog_addr.size()) ? dlog_addr[idx] : -1, addr);
        checkOutput({name, " dut data"}, (idx < dlog_data.size()) ? dlog_data[idx] : -1, data);
        checkOutput({name, " model addr"}, (idx < mlog_addr.size()) ? mlog_addr[idx] : -1, addr);
        checkOutput({name, " model data"}, (idx < mlog_data.size()) ? mlog_data[idx] : -1, data);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pat [8];
        pat = '{1, 0, 1, 1, 0, 0, 0, 1};

        $display("[TB] reset");
        step(2);
        checkOutput("reset active", int'(capture_active), 0);
        checkOutput("reset done", int'(capture_done), 0);
        checkOutput("reset wen", int'(bram_wen), 0);
        checkOutput("reset addr", int'(bram_addr), 0);
        checkOutput("reset data", int'(bram_write_data), 0);
        checkOutput("reset last", int'(capture_last_addr), 0);
        rst_n = 1'b1;
        step(2);

        $display("[TB] 8-bit linear capture");
        applyStimulus(1'b0, 1'b0, 3, 0, 0, 3);
        gpio_cap_in = 8'h11; step(1);
        gpio_cap_in = 8'h22; enable_cap = 1'b1; step(1);
        gpio_cap_in = 8'h33; step(1);
        gpio_cap_in = 8'h44; step(1);
        gpio_cap_in = 8'h00; step(6);
        checkOutput("t1 writes", dlog_addr.size(), 4);
        checkLog("t1 w0", 0, 0, 8'h11);
        checkLog("t1 w1", 1, 1, 8'h22);
        checkLog("t1 w2", 2, 2, 8'h33);
        checkLog("t1 w3", 3, 3, 8'h44);
        checkOutput("t1 done", int'(capture_done), 1);
        checkOutput("t1 last", int'(capture_last_addr), 3);
        enable_cap = 1'b0; step(2);
        checkOutput("t1 done cleared", int'(capture_done), 0);

        $display("[TB] 1-bit slow capture");
        applyStimulus(1'b0, 1'b0, 0, 1, 1, 0);
        gpio_cap_in = 8'(pat[0]); step(1);
        enable_cap = 1'b1; step(15);
        for (int i = 1; i < 8; i++) begin
            gpio_cap_in = 8'(pat[i]);
            step(16);
        end
        step(4);
        checkOutput("t2 model period", m_period, 16);
        checkOutput("t2 writes", dlog_addr.size(), 1);
        checkLog("t2 w0", 0, 0, 8'h8D);
        checkOutput("t2 done", int'(capture_done), 1);
        enable_cap = 1'b0; step(2);

        $display("[TB] triggered capture");
        applyStimulus(1'b0, 1'b1, 3, 0, 0, 0);
        gpio_cap_in = 8'h01; step(3);
        enable_cap = 1'b1; step(5);
        checkOutput("t3 armed high", int'(capture_active), 1);
        checkOutput("t3 no write high", dlog_addr.size(), 0);
        gpio_cap_in = 8'h00; step(4);
        checkOutput("t3 armed low", int'(capture_active), 1);
        checkOutput("t3 no write low", dlog_addr.size(), 0);
        gpio_cap_in = 8'h81; step(6);
        checkOutput("t3 writes", dlog_addr.size(), 1);
        checkLog("t3 w0", 0, 0, 8'h81);
        checkOutput("t3 done", int'(capture_done), 1);
        enable_cap = 1'b0; step(2);

        $display("[TB] circular capture");
        applyStimulus(1'b1, 1'b0, 3, 0, 0, 1);
        gpio_cap_in = 8'hA0; step(1);
        gpio_cap_in = 8'hA1; enable_cap = 1'b1; step(1);
        gpio_cap_in = 8'hA2; step(1);
        gpio_cap_in = 8'hA3; step(1);
        gpio_cap_in = 8'hA4; step(1);
        gpio_cap_in = 8'h00; step(2);
        enable_cap = 1'b0; step(1);
        checkOutput("t4 done", int'(capture_done), 1);
        checkOutput("t4 last", int'(capture_last_addr), 0);
        checkOutput("t4 writes", dlog_addr.size(), 5);
        checkLog("t4 w0", 0, 0, 8'hA0);
        checkLog("t4 w1", 1, 1, 8'hA1);
        checkLog("t4 w2", 2, 0, 8'hA2);
        checkLog("t4 w3", 3, 1, 8'hA3);
        checkLog("t4 w4", 4, 0, 8'hA4);
        step(2);
        checkOutput("t4 done cleared", int'(capture_done), 0);

        $display("[TB] 4-bit abort");
        applyStimulus(1'b0, 1'b0, 2, 0, 0, 5);
        gpio_cap_in = 8'h0F; enable_cap = 1'b1; step(2);
        enable_cap = 1'b0; step(3);
        checkOutput("t5 dut writes", dlog_addr.size(), 0);
        checkOutput("t5 model writes", mlog_addr.size(), 0);
        checkOutput("t5 active", int'(capture_active), 0);
        checkOutput("t5 done", int'(capture_done), 0);

        $display("[TB] async reset mid-capture");
        applyStimulus(1'b0, 1'b0, 3, 0, 0, 10);
        gpio_cap_in = 8'h55; enable_cap = 1'b1; step(4);
        checkOutput("t6 writes before reset", dlog_addr.size(), 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6 rst active", int'(capture_active), 0);
        checkOutput("t6 rst done", int'(capture_done), 0);
        checkOutput("t6 rst wen", int'(bram_wen), 0);
        checkOutput("t6 rst addr", int'(bram_addr), 0);
        checkOutput("t6 rst data", int'(bram_write_data), 0);
        checkOutput("t6 rst last", int'(capture_last_addr), 0);
        enable_cap = 1'b0; step(1);
        rst_n = 1'b1; gpio_cap_in = 8'h66; step(1);
        applyStimulus(1'b0, 1'b0, 3, 0, 0, 1);
        enable_cap = 1'b1; step(5);
        checkOutput("t6 restart writes", dlog_addr.size(), 2);
        checkLog("t6 w0", 0, 0, 8'h66);
        checkLog("t6 w1", 1, 1, 8'h66);
        checkOutput("t6 done", int'(capture_done), 1);
        enable_cap = 1'b0; step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pattern_capture.md
Name: pattern_capture

Overview:
- Logic-analyzer counterpart of the pattern generator: samples GPIO inputs on a programmable timestep, packs the samples into bytes, and writes them into the shared 8 KB block RAM.
- Sits on clk_100mhz beside the pattern generator and is configured by a SCARF regmap slave.
- The top-level BRAM mux selects this block while capture_active is high; SPI then reads the captured data back through the SCARF BRAM slave.

Parameters:
ADDR_BITS, 13, BRAM address width
SYNC_STAGES, 2, input synchronizer depth (minimum 2)

Ports:
clk  input  1  system clock (clk_100mhz)
rst_n  input  1  asynchronous active-low reset (rst_n_100mhz_sync at top)
enable_cap  input  1  level; high starts and holds a capture, low stops or aborts it
end_address_cap  input  ADDR_BITS  last BRAM address written
num_gpio_sel_cap  input  2  0=1 bit (gpio[0]), 1=2 bits, 2=4 bits, 3=8 bits per sample
timestep_sel_cap  input  3  sample every 2^(3*sel) stage1 ticks
stage1_count_sel_cap  input  4  one stage1 tick every sel+1 clocks
circular_enable_cap  input  1  wrap to address 0 after end_address_cap
trigger_enable_cap  input  1  wait for a rising edge on synchronized gpio_cap_in[0] before sampling
gpio_cap_in  input  8  asynchronous inputs being captured
capture_active  output  1  high in ARM and CAPTURE; drives the BRAM mux select
capture_done  output  1  high in DONE
capture_last_addr  output  ADDR_BITS  address of the most recent byte write
bram_addr  output  ADDR_BITS  write address
bram_write_data  output  8  packed sample byte
bram_wen  output  1  single-cycle write strobe

Behaviour:
- Reset values: all outputs 0; state IDLE; counters, shift register and synchronizers cleared.
- gpio_cap_in passes through SYNC_STAGES flops. Every use below refers to the synchronized value.
- State machine:
  - IDLE -> ARM on enable_cap=1, when trigger_enable_cap=1.
  - IDLE -> CAPTURE on enable_cap=1, when trigger_enable_cap=0.
  - ARM -> CAPTURE on the first cycle where sync gpio[0] is 1 and was 0 on the previous cycle.
  - ARM -> IDLE if enable_cap drops.
  - CAPTURE -> DONE on the write to end_address_cap when circular_enable_cap=0.
  - CAPTURE -> DONE if enable_cap drops while circular_enable_cap=1.
  - CAPTURE -> IDLE if enable_cap drops while circular_enable_cap=0 (abort; capture_done not set).
  - DONE -> IDLE when enable_cap=0.
- Config inputs are sampled on CAPTURE entry. Changes made during a capture are ignored.
- Timebase:
  - Stage1 counter counts 0..stage1_count_sel_cap and emits a tick on the wrap.
  - A 21-bit stage2 counter counts ticks 0..2^(3*timestep_sel)-1 and emits a sample strobe on the wrap.
  - Both counters clear on CAPTURE entry. The first sample is taken on the CAPTURE entry cycle itself.
  - Sample period = (stage1_count_sel+1)*2^(3*timestep_sel) clocks.
- Packing:
  - Each sample takes the low W = 1/2/4/8 bits of sync gpio.
  - Samples are packed LSB-first: first sample in bits [W-1:0].
  - 8/W samples make one byte.
- Writes:
  - On the cycle after the sample that completes a byte: bram_wen=1 for exactly one cycle, bram_write_data = packed byte, bram_addr = current address, capture_last_addr <= current address.
  - Address then increments.
  - At end_address_cap in circular mode, the address wraps to 0.
- Abort or stop mid-byte discards the partial byte. No write is issued.
- bram_wen is never asserted outside CAPTURE, except for the final write cycle that coincides with the DONE transition.
- end_address_cap=0: exactly one byte is written.
- Async reset mid-capture returns everything to reset values immediately. BRAM contents are untouched.

Test Plan:
- 8-bit mode, stage1_sel=0, timestep_sel=0, end=3, gpio driven 0x11,0x22,0x33,0x44 per clock -> four bram_wen pulses at addresses 0..3 with data 0x11..0x44; capture_done=1; capture_last_addr=3.
- 1-bit mode, stage1_sel=1, timestep_sel=1, gpio[0] pattern 1,0,1,1,0,0,0,1 -> one write of 0x8D at address 0 after 8 samples spaced 16 clocks apart.
- Trigger enabled, gpio[0] held 1 then 0 then 1 -> stays in ARM (capture_active=1, no writes) until the 0->1 edge; the first sample is taken on the CAPTURE entry cycle.
- Circular mode, end=1, 8-bit mode, enable held for 5 samples then dropped -> addresses 0,1,0,1,0; capture_done=1; capture_last_addr=0.
- 4-bit mode, enable dropped after 1 sample (non-circular) -> no bram_wen, returns to IDLE, capture_done stays 0.
- rst_n pulsed low mid-CAPTURE -> all outputs 0 asynchronously; a new enable restarts at address 0.
